seq_mul_4b: RTL

SEQ_MUL_4B -- requirements
Module: seq_mul_4b

---
 rtl/seq_mul_4b.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_mul_4b.sv
// Sequential 4x4 unsigned multiplier: four shift-add steps through a 4-bit
// carry-lookahead adder, with valid/ready handshakes on both sides.

module cla_add_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_i,
    output logic [3:0] s,
    output logic       c_o
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s    = a & b;
    assign p_s    = a ^ b;
    assign c_s[0] = c_i;
    assign c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign s      = p_s ^ c_s[3:0];
    assign c_o    = c_s[4];
endmodule

module seq_mul_4b (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    logic [7:0] acc_q,   acc_d;
    logic [1:0] cnt_q,   cnt_d;
    logic [3:0] sum_s;
    logic       cout_s;

    cla_add_4b u_add (
        .a   (acc_q[7:4]),
        .b   (mcand_q),
        .c_i (1'b0),
        .s   (sum_s),
        .c_o (cout_s)
    );

    // Next-state and datapath: the carry above acc[7] is always zero after a
    // shift, so the adder carry-out lands directly in acc[7].
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mcand_d = in_a;
                    acc_d   = {4'h0, in_b};
                    cnt_d   = 2'd0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (acc_q[0]) begin
                    acc_d = {cout_s, sum_s, acc_q[3:1]};
                end else begin
                    acc_d = {1'b0, acc_q[7:4], acc_q[3:1]};
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mcand_q <= 4'h0;
            acc_q   <= 8'h00;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = acc_q;
endmodule
